// File: rtl/ss_dmem_mmio.sv
// ----------------------------------------------------------------------------
// ss_dmem_mmio
// Data-side responder for the single-cycle core: a word-addressed RAM plus a
// small memory-mapped I/O block (console TX FIFO, machine timer, timer IRQ).
// Loads are answered combinationally so the core finishes a load in one cycle;
// every state change happens on the rising clock edge.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   Addr       byte address; Addr[31] selects MMIO, Addr[1:0] ignored
//   WriteData  store data
//   MemWrite   store strobe, one write per cycle while high
//   ReadData   combinational load data for Addr
//   tx_data    console byte at FIFO head (valid only with tx_valid)
//   tx_valid   FIFO non-empty
//   tx_ready   consumer accepts the head byte when tx_valid & tx_ready
//   irq        timer interrupt pending (registered)
//
// MMIO map (Addr[4:2]): 0x00 CONSOLE_DATA, 0x04 CONSOLE_STATUS, 0x08 MTIME,
// 0x0C MTIMECMP, 0x10 IRQ_STATUS, 0x14-0x1C read as zero.
// ----------------------------------------------------------------------------
module ss_dmem_mmio #(
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] OFF_CON_DATA   = 3'd0;
    localparam logic [2:0] OFF_CON_STATUS = 3'd1;
    localparam logic [2:0] OFF_MTIME      = 3'd2;
    localparam logic [2:0] OFF_MTIMECMP   = 3'd3;
    localparam logic [2:0] OFF_IRQ_STATUS = 3'd4;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          is_mmio;
    logic [2:0]    off;
    logic [AW-1:0] ram_idx;

    assign is_mmio = Addr[31];
    assign off     = Addr[4:2];
    assign ram_idx = Addr[AW+1:2];   // upper RAM-region bits alias

    // Byte offset and the high address bits only matter through the fields above.
    logic unused_addr;
    assign unused_addr = ^{Addr[30:5], Addr[1:0]};

    logic wr_ram, wr_con_data, wr_con_status, wr_mtime, wr_mtimecmp, wr_irq_status;
    assign wr_ram        = MemWrite & ~is_mmio;
    assign wr_con_data   = MemWrite & is_mmio & (off == OFF_CON_DATA);
    assign wr_con_status = MemWrite & is_mmio & (off == OFF_CON_STATUS);
    assign wr_mtime      = MemWrite & is_mmio & (off == OFF_MTIME);
    assign wr_mtimecmp   = MemWrite & is_mmio & (off == OFF_MTIMECMP);
    assign wr_irq_status = MemWrite & is_mmio & (off == OFF_IRQ_STATUS);

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [31:0] ram [DEPTH_WORDS];

    // NOTE: storage arrays get no reset branch; resetting a memory forces it
    // into flops instead of a RAM macro, and nothing relies on its contents.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          overflow;
    logic          fifo_empty, fifo_full, pop, push_ok, push_drop;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign tx_valid   = ~fifo_empty;
    assign tx_data    = fifo_mem[head];
    assign pop        = tx_valid & tx_ready;
    // A push into a full FIFO still fits if the head leaves in the same cycle.
    assign push_ok    = wr_con_data & (~fifo_full | pop);
    assign push_drop  = wr_con_data & fifo_full & ~pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[tail] <= WriteData[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Timer and control state
    // ------------------------------------------------------------------
    logic [31:0] mtime, mtimecmp;
    logic        pending;

    assign irq = pending;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, e.g. the timer match below compares the old mtime.
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            mtime    <= '0;
            mtimecmp <= '1;
            pending  <= 1'b0;
        end else begin
            if (push_ok) tail <= tail + PW'(1);
            if (pop)     head <= head + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A dropped byte outranks a same-cycle clear.
            if (push_drop)          overflow <= 1'b1;
            else if (wr_con_status) overflow <= 1'b0;

            mtime <= wr_mtime ? WriteData : mtime + 32'd1;
            if (wr_mtimecmp) mtimecmp <= WriteData;

            // A match outranks a same-cycle clear.
            if (mtime == mtimecmp)                      pending <= 1'b1;
            else if (wr_irq_status && WriteData[0])     pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read mux (no side effects)
    // ------------------------------------------------------------------
    // NOTE: ReadData gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        ReadData = '0;
        if (!is_mmio) begin
            ReadData = ram[ram_idx];
        end else begin
            case (off)
                OFF_CON_STATUS: ReadData = {29'b0, overflow, fifo_full, fifo_empty};
                OFF_MTIME:      ReadData = mtime;
                OFF_MTIMECMP:   ReadData = mtimecmp;
                OFF_IRQ_STATUS: ReadData = {31'b0, pending};
                default:        ReadData = '0;
            endcase
        end
    end

endmodule
